// File: rtl/uart_rx_param_pkg.sv
// uart_pkg: shared types and constants for the parametrised UART receiver.
// FSM state encoding, parity mode constants and a 2-of-3 vote helper used by
// the sampler when UART_RX_MAJORITY_EN is defined.
package uart_pkg;

  // Receiver FSM states. S_BREAK parks the FSM while the line is held low
  // after a framing error, so a long break is not mistaken for new frames.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } rx_state_e;

  // Parity modes for the PARITY parameter.
  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Two-of-three majority vote.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// uart_rx_param_if: byte-side port bundle of the UART receiver.
//
// Handshake: the receiver (master) raises rx_valid when rx_data holds an
// unconsumed word and keeps rx_data stable until the consumer (slave) takes
// it. A transfer happens on every rising clk edge where rx_valid && rx_ready;
// rx_valid drops on the following cycle unless a new word is loaded on that
// very edge. rx_ready may be held high permanently. The error flags and busy
// are status outputs, not part of the handshake; each error flag is a
// single-cycle pulse.
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 frame_err;
  logic                 parity_err;
  logic                 overrun_err;
  logic                 busy;

  // Receiver side
  modport master (
    output rx_data, rx_valid, frame_err, parity_err, overrun_err, busy,
    input  rx_ready
  );

  // Consumer side
  modport slave (
    input  rx_data, rx_valid, frame_err, parity_err, overrun_err, busy,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: brings the asynchronous serial pin into the clk domain and
// produces the bit value the receiver FSM samples.
// Build option UART_RX_MAJORITY_EN: when defined, sample_bit is the majority
// of the synchronized line over the current and two previous cycles, so a
// decision taken one cycle after the nominal mid-bit point votes over
// mid-1, mid and mid+1. When undefined, sample_bit is simply rxs.
module uart_rx_sampler
  import uart_pkg::*;
(
  input  logic clk,
  input  logic Rst_rx,
  input  logic Rs232,
  output logic rxs,
  output logic sample_bit
);

  logic sync1_q;
  logic sync2_q;

  // Two-flop synchronizer; both flops reset to the idle-high line level.
  always_ff @(posedge clk or negedge Rst_rx) begin
    if (!Rst_rx) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= Rs232;
      sync2_q <= sync1_q;
    end
  end

  assign rxs = sync2_q;

`ifdef UART_RX_MAJORITY_EN
  logic hist1_q;
  logic hist2_q;

  // History of the synchronized line for the 3-sample vote.
  always_ff @(posedge clk or negedge Rst_rx) begin
    if (!Rst_rx) begin
      hist1_q <= 1'b1;
      hist2_q <= 1'b1;
    end else begin
      hist1_q <= sync2_q;
      hist2_q <= hist1_q;
    end
  end

  assign sample_bit = maj3(sync2_q, hist1_q, hist2_q);
`else
  assign sample_bit = sync2_q;
`endif

endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver (5..9 data bits, none/odd/even
// parity, 1 or 2 stop bits) with false-start rejection, framing/parity/
// overrun error pulses and a valid/ready word output.
// Build option UART_RX_MAJORITY_EN: 2-of-3 majority sampling around mid-bit;
// every decision point, and therefore every latency, moves one cycle later.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = PAR_NONE,
  parameter int STOP_BITS    = 1
) (
  input  logic          clk,
  input  logic          Rst_rx,
  input  logic          Rs232,
  uart_rx_param_if.master rx_if,
  output rx_state_e     state_dbg
);

`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ_DLY = 1;
`else
  localparam int MAJ_DLY = 0;
`endif

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);

  // Last count of a bit period; the counter wraps here, and after the start
  // decision realigns it this is also the (voted) mid-bit sample point.
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(CLKS_PER_BIT - 1);
  // Start-bit check half a bit after the falling edge (plus vote delay).
  localparam logic [CNT_W-1:0] START_DEC = CNT_W'(CLKS_PER_BIT / 2 - 1 + MAJ_DLY);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);
  localparam logic             LAST_STOP = (STOP_BITS == 2);
  localparam logic             ODD_MODE  = (PARITY == PAR_ODD);
  localparam logic             HAS_PAR   = (PARITY != PAR_NONE);

  logic rxs;
  logic samp;

  uart_rx_sampler u_sampler (
    .clk        (clk),
    .Rst_rx     (Rst_rx),
    .Rs232      (Rs232),
    .rxs        (rxs),
    .sample_bit (samp)
  );

  rx_state_e            state_q,    state_d;
  logic [CNT_W-1:0]     cnt_q,      cnt_d;
  logic [IDX_W-1:0]     idx_q,      idx_d;
  logic [DATA_BITS-1:0] shreg_q,    shreg_d;
  logic                 par_bad_q,  par_bad_d;
  logic                 stop_bad_q, stop_bad_d;
  logic                 stop_n_q,   stop_n_d;
  logic [DATA_BITS-1:0] data_q,     data_d;
  logic                 valid_q,    valid_d;
  logic                 fe_q,       fe_d;
  logic                 pe_q,       pe_d;
  logic                 oe_q,       oe_d;

  logic tick;
  logic accept;
  logic stop_bad_now;
  logic par_calc;

  assign tick         = (cnt_q == LAST_CNT);
  assign accept       = valid_q & rx_if.rx_ready;
  assign stop_bad_now = stop_bad_q | ~samp;
  assign par_calc     = (^shreg_q) ^ samp;

  // State and datapath registers; reset aborts any frame in progress.
  always_ff @(posedge clk or negedge Rst_rx) begin
    if (!Rst_rx) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      shreg_q    <= '0;
      par_bad_q  <= 1'b0;
      stop_bad_q <= 1'b0;
      stop_n_q   <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      fe_q       <= 1'b0;
      pe_q       <= 1'b0;
      oe_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shreg_q    <= shreg_d;
      par_bad_q  <= par_bad_d;
      stop_bad_q <= stop_bad_d;
      stop_n_q   <= stop_n_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      fe_q       <= fe_d;
      pe_q       <= pe_d;
      oe_q       <= oe_d;
    end
  end

  // Next-state, baud counter, bit capture and end-of-frame verdict.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shreg_d    = shreg_q;
    par_bad_d  = par_bad_q;
    stop_bad_d = stop_bad_q;
    stop_n_d   = stop_n_q;
    data_d     = data_q;
    valid_d    = accept ? 1'b0 : valid_q;
    fe_d       = 1'b0;
    pe_d       = 1'b0;
    oe_d       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rxs) state_d = S_START;
      end

      S_START: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == START_DEC) begin
          cnt_d = '0;
          if (!samp) begin
            state_d    = S_DATA;
            idx_d      = '0;
            par_bad_d  = 1'b0;
            stop_bad_d = 1'b0;
            stop_n_d   = 1'b0;
          end else begin
            // Line already back high: a glitch, not a start bit.
            state_d = S_IDLE;
          end
        end
      end

      S_DATA: begin
        cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        if (tick) begin
          shreg_d[idx_q] = samp;
          if (idx_q == LAST_IDX) begin
            state_d = HAS_PAR ? S_PARITY : S_STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end

      S_PARITY: begin
        cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        if (tick) begin
          // Odd mode wants an overall XOR of 1, even mode wants 0.
          par_bad_d = (par_calc != ODD_MODE);
          state_d   = S_STOP;
        end
      end

      S_STOP: begin
        cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        if (tick) begin
          if (stop_n_q == LAST_STOP) begin
            // Verdict at mid-stop so a following start edge is not missed.
            state_d = S_IDLE;
            if (stop_bad_now) begin
              fe_d = 1'b1;
              if (!rxs) state_d = S_BREAK;
            end else if (par_bad_q) begin
              pe_d = 1'b1;
            end else if (valid_q && !accept) begin
              oe_d = 1'b1;
            end else begin
              data_d  = shreg_q;
              valid_d = 1'b1;
            end
          end else begin
            stop_bad_d = stop_bad_now;
            stop_n_d   = 1'b1;
          end
        end
      end

      S_BREAK: begin
        cnt_d = '0;
        if (rxs) state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign rx_if.rx_data     = data_q;
  assign rx_if.rx_valid    = valid_q;
  assign rx_if.frame_err   = fe_q;
  assign rx_if.parity_err  = pe_q;
  assign rx_if.overrun_err = oe_q;
  assign rx_if.busy        = (state_q != S_IDLE);
  assign state_dbg         = state_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: directed bench for uart_rx_param. Three receivers with
// different frame formats share clk and reset: A = 8N1, B = 7E1, C = 8N2.
// Expected output events are queued per receiver as frames are sent; a
// monitor compares whatever each receiver presents against its queue.
module tb_uart_rx_param;
  import uart_pkg::*;

  localparam int CPB = 16;

  localparam logic [1:0] EV_WORD = 2'd0;
  localparam logic [1:0] EV_FE   = 2'd1;
  localparam logic [1:0] EV_PE   = 2'd2;
  localparam logic [1:0] EV_OE   = 2'd3;

  logic clk    = 1'b0;
  logic Rst_rx = 1'b0;
  logic line_a = 1'b1;
  logic line_b = 1'b1;
  logic line_c = 1'b1;

  rx_state_e st_a, st_b, st_c;

  int n_vec  = 0;
  int n_fail = 0;

  // Event = {kind, data}
  logic [10:0] exp_q_a[$];
  logic [10:0] exp_q_b[$];
  logic [10:0] exp_q_c[$];

  uart_rx_param_if #(.DATA_BITS(8)) if_a ();
  uart_rx_param_if #(.DATA_BITS(7)) if_b ();
  uart_rx_param_if #(.DATA_BITS(8)) if_c ();

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(1)) dut_a (
    .clk(clk), .Rst_rx(Rst_rx), .Rs232(line_a), .rx_if(if_a), .state_dbg(st_a));
  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(PAR_EVEN), .STOP_BITS(1)) dut_b (
    .clk(clk), .Rst_rx(Rst_rx), .Rs232(line_b), .rx_if(if_b), .state_dbg(st_b));
  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(2)) dut_c (
    .clk(clk), .Rst_rx(Rst_rx), .Rs232(line_c), .rx_if(if_c), .state_dbg(st_c));

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running, required finished");
    $fatal(1, "timeout");
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
    end
  endtask

  task automatic sb_pop(input int which, input logic [10:0] got);
    logic [10:0] e;
    bit          have;
    e    = '0;
    have = 1'b0;
    case (which)
      0: if (exp_q_a.size() > 0) begin e = exp_q_a.pop_front(); have = 1'b1; end
      1: if (exp_q_b.size() > 0) begin e = exp_q_b.pop_front(); have = 1'b1; end
      default: if (exp_q_c.size() > 0) begin e = exp_q_c.pop_front(); have = 1'b1; end
    endcase
    n_vec++;
    if (!have) begin
      n_fail++;
      $display("FAIL sb_%0d: got kind=%0d data=0x%0h, required no event", which, got[10:9], got[8:0]);
    end else if (got !== e) begin
      n_fail++;
      $display("FAIL sb_%0d: got kind=%0d data=0x%0h, required kind=%0d data=0x%0h",
               which, got[10:9], got[8:0], e[10:9], e[8:0]);
    end
  endtask

  task automatic mon_one(input int which, input logic vld, input logic rdy, input logic [8:0] dat,
                         input logic fe, input logic pe, input logic oe);
    if (vld && rdy) sb_pop(which, {EV_WORD, dat});
    if (fe)         sb_pop(which, {EV_FE, 9'd0});
    if (pe)         sb_pop(which, {EV_PE, 9'd0});
    if (oe)         sb_pop(which, {EV_OE, 9'd0});
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (Rst_rx) begin
      mon_one(0, if_a.rx_valid, if_a.rx_ready, 9'(if_a.rx_data), if_a.frame_err, if_a.parity_err, if_a.overrun_err);
      mon_one(1, if_b.rx_valid, if_b.rx_ready, 9'(if_b.rx_data), if_b.frame_err, if_b.parity_err, if_b.overrun_err);
      mon_one(2, if_c.rx_valid, if_c.rx_ready, 9'(if_c.rx_data), if_c.frame_err, if_c.parity_err, if_c.overrun_err);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_line(input int which, input logic v);
    case (which)
      0: line_a = v;
      1: line_b = v;
      default: line_c = v;
    endcase
  endtask

  task automatic drive_bit(input int which, input logic v);
    set_line(which, v);
    repeat (CPB) @(posedge clk);
  endtask

  task automatic send_frame(input int which, input logic [8:0] data, input int nbits,
                            input bit has_par, input logic pbit,
                            input logic [1:0] stops, input int nstop);
    drive_bit(which, 1'b0);
    for (int i = 0; i < nbits; i++) drive_bit(which, data[i]);
    if (has_par) drive_bit(which, pbit);
    for (int i = 0; i < nstop; i++) drive_bit(which, stops[i]);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    if_a.rx_ready = 1'b1;
    if_b.rx_ready = 1'b1;
    if_c.rx_ready = 1'b1;

    // Reset values
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rst_valid_a", 32'(if_a.rx_valid), 32'd0);
    chk("rst_data_a",  32'(if_a.rx_data),  32'd0);
    chk("rst_busy_a",  32'(if_a.busy),     32'd0);
    chk("rst_errs_a",  32'({if_a.frame_err, if_a.parity_err, if_a.overrun_err}), 32'd0);
    chk("rst_state_a", 32'(st_a), 32'(S_IDLE));
    Rst_rx = 1'b1;
    repeat (CPB) @(posedge clk);

    // 8N1 0xA5
    exp_q_a.push_back({EV_WORD, 9'h0A5});
    send_frame(0, 9'h0A5, 8, 1'b0, 1'b0, 2'b11, 1);
    repeat (CPB) @(posedge clk);

    // 7E1: 0x41 has two ones, p=0 is good; p=1 is a parity error
    exp_q_b.push_back({EV_WORD, 9'h041});
    send_frame(1, 9'h041, 7, 1'b1, 1'b0, 2'b11, 1);
    exp_q_b.push_back({EV_PE, 9'd0});
    send_frame(1, 9'h041, 7, 1'b1, 1'b1, 2'b11, 1);
    repeat (CPB) @(posedge clk);
    @(negedge clk);
    chk("par_valid_b", 32'(if_b.rx_valid), 32'd0);
    chk("par_data_b",  32'(if_b.rx_data),  32'h41);

    // 8N2, second stop low, then line held low: frame error and break
    exp_q_c.push_back({EV_FE, 9'd0});
    send_frame(2, 9'h055, 8, 1'b0, 1'b0, 2'b01, 2);
    for (int k = 0; k < 4; k++) begin
      repeat (10 * CPB) @(posedge clk);
      @(negedge clk);
      chk("break_busy_c", 32'(if_c.busy), 32'd1);
    end
    chk("break_state_c", 32'(st_c), 32'(S_BREAK));
    chk("break_valid_c", 32'(if_c.rx_valid), 32'd0);
    set_line(2, 1'b1);
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("break_exit_c", 32'(if_c.busy), 32'd0);

    // Glitch shorter than half a bit on A
    set_line(0, 1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("glitch_busy_hi_a", 32'(if_a.busy), 32'd1);
    set_line(0, 1'b1);
    repeat (3 * CPB) @(posedge clk);
    @(negedge clk);
    chk("glitch_busy_lo_a", 32'(if_a.busy), 32'd0);
    chk("glitch_valid_a",   32'(if_a.rx_valid), 32'd0);

    // Overrun: consumer stalled, two back-to-back frames
    @(posedge clk);
    if_a.rx_ready = 1'b0;
    exp_q_a.push_back({EV_OE, 9'd0});
    exp_q_a.push_back({EV_WORD, 9'h011});
    send_frame(0, 9'h011, 8, 1'b0, 1'b0, 2'b11, 1);
    send_frame(0, 9'h022, 8, 1'b0, 1'b0, 2'b11, 1);
    @(negedge clk);
    chk("ovr_valid_a", 32'(if_a.rx_valid), 32'd1);
    chk("ovr_data_a",  32'(if_a.rx_data),  32'h11);
    if_a.rx_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("ovr_drain_a", 32'(if_a.rx_valid), 32'd0);

    // Reset mid-DATA, then a clean 0x3C frame
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_busy_a", 32'(if_a.busy), 32'd1);
    Rst_rx = 1'b0;
    set_line(0, 1'b1);
    #1;
    chk("mid_rst_busy_a", 32'(if_a.busy), 32'd0);
    chk("mid_rst_state_a", 32'(st_a), 32'(S_IDLE));
    chk("mid_rst_data_a", 32'(if_a.rx_data), 32'd0);
    chk("mid_rst_outs_a", 32'({if_a.rx_valid, if_a.frame_err, if_a.parity_err, if_a.overrun_err}), 32'd0);
    repeat (3) @(negedge clk);
    Rst_rx = 1'b1;
    repeat (CPB) @(posedge clk);
    exp_q_a.push_back({EV_WORD, 9'h03C});
    send_frame(0, 9'h03C, 8, 1'b0, 1'b0, 2'b11, 1);

    // Bounded drain of outstanding expectations
    for (int t = 0; t < 400; t++) begin
      if (exp_q_a.size() == 0 && exp_q_b.size() == 0 && exp_q_c.size() == 0) break;
      @(posedge clk);
    end
    repeat (2 * CPB) @(posedge clk);
    @(negedge clk);
    chk("drain_a", 32'(exp_q_a.size()), 32'd0);
    chk("drain_b", 32'(exp_q_b.size()), 32'd0);
    chk("drain_c", 32'(exp_q_c.size()), 32'd0);
    chk("end_data_a", 32'(if_a.rx_data), 32'h3C);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receiver, next generation of the fixed 8N1 receiver. Supports configurable bit period, 5–9 data bits, none/odd/even parity and 1 or 2 stop bits, with false-start rejection, framing/parity/overrun error reporting and a valid/ready handshake to the consumer. It sits between the asynchronous serial pin and the byte-level consumer (FIFO or command parser) in the same clock domain.

## Interface
- CLKS_PER_BIT, 5208, clk cycles per serial bit; legal range ≥ 4
- DATA_BITS, 8, data bits per frame; legal range 5..9
- PARITY, 0, parity mode: 0 none, 1 odd, 2 even
- STOP_BITS, 1, stop bits checked: 1 or 2
- clk  in  1  system clock; single clock domain
- Rst_rx  in  1  asynchronous, active-low reset
- Rs232  in  1  serial line, asynchronous, idle high
- rx_data  out  DATA_BITS  received word, LSB received first
- rx_valid  out  1  rx_data holds an unconsumed word
- rx_ready  in  1  consumer accepts word when rx_valid && rx_ready
- frame_err  out  1  one-cycle pulse: a stop bit sampled low
- parity_err  out  1  one-cycle pulse: parity mismatch
- overrun_err  out  1  one-cycle pulse: good word completed while rx_valid still high
- busy  out  1  high in any state other than IDLE

## Operation
- Rs232 passes through a 2-flop synchronizer (both flops reset to 1); all logic uses the synchronized line `rxs`.
- States: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE: on rxs==0 → START, baud counter cleared.
- START: at count CLKS_PER_BIT/2−1, sample. Low → DATA, counter cleared, bit index 0. High → IDLE (false start, no flag).
- DATA: sample every CLKS_PER_BIT cycles into bit[index], LSB first. After bit DATA_BITS−1 → PARITY if PARITY≠0, else STOP.
- PARITY: one sample. Odd: XOR(data, p) must be 1. Even: must be 0. Mismatch is latched; → STOP.
- STOP: sample STOP_BITS times, one bit period apart. After the last sample:
  - any stop low → frame_err pulse; → BREAK if rxs==0, else IDLE
  - else parity mismatch → parity_err pulse; → IDLE
  - else if rx_valid==1 → overrun_err pulse, word dropped, rx_data unchanged; → IDLE
  - else rx_data ← word, rx_valid ← 1; → IDLE
- BREAK: wait for rxs==1 → IDLE.
- Frame error takes priority over parity error; only one error pulses per frame.
- rx_valid clears on the cycle after rx_valid && rx_ready. An acceptance in the same cycle as a new word load leaves rx_valid=1 with the new word; no overrun is flagged.
- Unused upper bits do not exist: rx_data is exactly DATA_BITS wide.

## Timing
- Reset values: rx_data=0, rx_valid=0, frame_err=0, parity_err=0, overrun_err=0, busy=0, state=IDLE, counters=0.
- Reset asserted mid-frame aborts immediately; the partial word is discarded with no flags.
- Baud counter width is $clog2(CLKS_PER_BIT); it wraps to 0 at CLKS_PER_BIT−1.
- Latency: rx_valid rises 1 cycle after the final stop-bit sample (mid-stop), about (1+DATA_BITS+P+STOP_BITS−0.5)·CLKS_PER_BIT + 3 cycles after the Rs232 falling edge.
- Returning to IDLE at mid-stop allows back-to-back frames with no idle gap.

## Configuration
- UART_RX_MAJORITY_EN defined: each sample is the 2-of-3 majority of rxs at counts mid−1, mid and mid+1. The decision is taken at mid+1, and all latencies grow by 1 cycle.
- Undefined: each sample is a single read of rxs at mid.

## Structure
- Package uart_pkg:
  - state enum (IDLE..BREAK)
  - parity constants PAR_NONE/PAR_ODD/PAR_EVEN
- Sub-module uart_rx_sampler: synchronizer plus optional majority voter. Outputs `rxs` and a sample value for the FSM.

## Test plan
- CLKS_PER_BIT=16, 8N1, byte 0xA5, rx_ready=1 → rx_valid pulse with rx_data=0xA5; no errors.
- DATA_BITS=7, PARITY=2, word 0x41 with p=0 → rx_data=0x41. Same frame with p flipped → parity_err pulse, rx_valid stays 0.
- STOP_BITS=2, second stop driven low → frame_err pulse. Line then held low 40 bit-times → busy stays 1 (BREAK) until the line goes high.
- Glitch low for 5 cycles (< CLKS_PER_BIT/2) → no rx_valid, no error; returns to IDLE.
- rx_ready=0, frames 0x11 then 0x22 sent back-to-back → rx_valid=1 with rx_data=0x11 and an overrun_err pulse at the end of the 0x22 frame.
- Rst_rx pulled low mid-DATA, then a clean 0x3C frame → only 0x3C delivered; all outputs 0 during reset.
